// File: rtl/trng_pkg.sv
// Shared definitions for the TRNG post-processing blocks: default sizes and
// the bit-packer state encoding.
package trng_pkg;

  localparam int WORD_W_DEF    = 32;
  localparam int REP_LIMIT_DEF = 16;
  localparam int OVR_W_DEF     = 16;

  typedef enum logic [1:0] {
    ST_FILL,
    ST_PENDING,
    ST_FAIL
  } pack_state_e;

endpackage

// File: rtl/trng_bit_packer_if.sv
// Word handshake between the bit packer and the chaos-map seeding logic.
interface trng_bit_packer_if import trng_pkg::*; #(
  parameter int WORD_W = WORD_W_DEF
) ();

  logic              word_valid;
  logic              word_ready;
  logic [WORD_W-1:0] word_data;

  modport master (output word_valid, output word_data, input word_ready);
  modport slave  (input word_valid, input word_data, output word_ready);

endinterface

// File: rtl/trng_rep_count_test.sv
// Continuous repetition-count health test; fail is a same-cycle pulse raised
// while the bit that completes a run of REP_LIMIT identical bits is offered.
module trng_rep_count_test import trng_pkg::*; #(
  parameter int REP_LIMIT = REP_LIMIT_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic bit_valid,
  input  logic bit_in,
  input  logic clr,
  output logic fail
);

  localparam int RUN_W = $clog2(REP_LIMIT + 1);

  logic [RUN_W-1:0] run_len;
  logic [RUN_W-1:0] run_len_nxt;
  logic             last_bit;

  // run_len == 0 means no reference bit yet (after reset or clear).
  always_comb begin
    // NOTE: default assignment first so no path leaves run_len_nxt unassigned (no latch).
    run_len_nxt = RUN_W'(1);
    if (run_len != '0 && bit_in == last_bit)
      run_len_nxt = (run_len == RUN_W'(REP_LIMIT)) ? run_len : run_len + RUN_W'(1);
  end

  assign fail = bit_valid && !clr && (run_len_nxt == RUN_W'(REP_LIMIT));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_len  <= '0;
      last_bit <= 1'b0;
    end else if (clr) begin
      run_len  <= '0;
    end else if (bit_valid) begin
      run_len  <= run_len_nxt;
      last_bit <= bit_in;
    end
  end

endmodule

// File: rtl/trng_bit_packer.sv
// Packs debiased corrector bits MSB-first into words behind a one-deep output
// slot, counting overruns and blocking output while the health test fails.
module trng_bit_packer import trng_pkg::*; #(
  parameter int WORD_W    = WORD_W_DEF,
  parameter int REP_LIMIT = REP_LIMIT_DEF,
  parameter int OVR_W     = OVR_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 bit_valid,
  input  logic                 bit_in,
  trng_bit_packer_if.master    word_if,
  output logic                 health_fail,
  input  logic                 health_clr,
  output logic [OVR_W-1:0]     overrun_cnt
);

  localparam int CNT_W = $clog2(WORD_W + 1);

  pack_state_e       state;
  logic [WORD_W-1:0] acc;
  logic [WORD_W-1:0] acc_shift;
  logic [CNT_W-1:0]  cnt;
  logic              rep_fail;
  logic              slot_free;
  logic              word_done;

  trng_rep_count_test #(.REP_LIMIT(REP_LIMIT)) u_rep_test (
    .clk       (clk),
    .reset_n   (reset_n),
    .bit_valid (bit_valid),
    .bit_in    (bit_in),
    .clr       (health_clr),
    .fail      (rep_fail)
  );

  assign slot_free = !word_if.word_valid || word_if.word_ready;
  assign acc_shift = {acc[WORD_W-2:0], bit_in};
  assign word_done = (cnt == CNT_W'(WORD_W - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state              <= ST_FILL;
      acc                <= '0;
      cnt                <= '0;
      word_if.word_valid <= 1'b0;
      word_if.word_data  <= '0;
      health_fail        <= 1'b0;
      overrun_cnt        <= '0;
    end else begin
      // A handshake empties the slot unless a new word is loaded below.
      if (word_if.word_valid && word_if.word_ready)
        word_if.word_valid <= 1'b0;

      if (health_clr) begin
        state       <= ST_FILL;
        health_fail <= 1'b0;
        acc         <= '0;
        cnt         <= '0;
      end else if (rep_fail || state == ST_FAIL) begin
        state       <= ST_FAIL;
        health_fail <= 1'b1;
        acc         <= '0;
        cnt         <= '0;
      end else begin
        unique case (state)
          ST_FILL: begin
            if (bit_valid) begin
              acc <= acc_shift;
              if (!word_done) begin
                cnt <= cnt + CNT_W'(1);
              end else if (slot_free) begin
                word_if.word_data  <= acc_shift;
                word_if.word_valid <= 1'b1;
                cnt                <= '0;
              end else begin
                cnt   <= CNT_W'(WORD_W);
                state <= ST_PENDING;
              end
            end
          end
          ST_PENDING: begin
            // Even the bit offered in the transfer cycle has nowhere to go.
            if (bit_valid && overrun_cnt != '1)
              overrun_cnt <= overrun_cnt + OVR_W'(1);
            if (slot_free) begin
              word_if.word_data  <= acc;
              word_if.word_valid <= 1'b1;
              cnt                <= '0;
              state              <= ST_FILL;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_trng_bit_packer.sv
// Bench for trng_bit_packer: directed scenarios plus random traffic, checked
// against a queue-based model through a handshake-driven scoreboard.
module tb_trng_bit_packer;

  localparam int W       = 8;
  localparam int R       = 4;
  localparam int O       = 4;
  localparam int OVR_MAX = (1 << O) - 1;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         bit_valid;
  logic         bit_in;
  logic         health_clr;
  logic         health_fail;
  logic [O-1:0] overrun_cnt;

  trng_bit_packer_if #(.WORD_W(W)) word_if ();

  trng_bit_packer #(.WORD_W(W), .REP_LIMIT(R), .OVR_W(O)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bit_valid   (bit_valid),
    .bit_in      (bit_in),
    .word_if     (word_if),
    .health_fail (health_fail),
    .health_clr  (health_clr),
    .overrun_cnt (overrun_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: collected bits in a queue, a one-word output slot,
  // a run counter and a saturating drop counter.
  bit          m_acc[$];
  logic        m_valid;
  logic [W-1:0] m_data;
  int          m_run;
  bit          m_last;
  bit          m_fail;
  int          m_ovr;
  logic [W-1:0] exp_q[$];

  task automatic model_reset();
    m_acc.delete();
    m_valid = 1'b0;
    m_data  = '0;
    m_run   = 0;
    m_last  = 1'b0;
    m_fail  = 1'b0;
    m_ovr   = 0;
    exp_q.delete();
  endtask

  task automatic model_step(input bit bv, input bit b, input bit rdy, input bit clr);
    bit           consumed;
    bit           load;
    bit           fail_now;
    logic [W-1:0] w;
    consumed = m_valid && rdy;
    load     = 1'b0;
    fail_now = 1'b0;
    w        = '0;
    if (clr) begin
      m_fail = 1'b0;
      m_run  = 0;
      m_acc.delete();
    end else begin
      if (bv) begin
        if (m_run > 0 && b == m_last) m_run = (m_run < R) ? m_run + 1 : R;
        else                          m_run = 1;
        m_last   = b;
        fail_now = (m_run == R);
      end
      if (m_fail || fail_now) begin
        m_fail = 1'b1;
        m_acc.delete();
      end else if (m_acc.size() == W) begin
        if (bv) m_ovr = (m_ovr < OVR_MAX) ? m_ovr + 1 : OVR_MAX;
        if (!m_valid || rdy) load = 1'b1;
      end else if (bv) begin
        m_acc.push_back(b);
        if (m_acc.size() == W && (!m_valid || rdy)) load = 1'b1;
      end
      if (load) begin
        foreach (m_acc[i]) w[W-1-i] = m_acc[i];
        m_acc.delete();
      end
    end
    if (load) begin
      m_valid = 1'b1;
      m_data  = w;
      exp_q.push_back(w);
    end else if (consumed) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic drive(input bit bv, input bit b, input bit rdy, input bit clr);
    @(negedge clk);
    bit_valid          = bv;
    bit_in             = b;
    word_if.word_ready = rdy;
    health_clr         = clr;
    @(posedge clk);
    model_step(bv, b, rdy, clr);
    #1;
  endtask

  task automatic send_bits(input logic [31:0] v, input int n, input bit rdy, input int max_gap);
    for (int i = n - 1; i >= 0; i--) begin
      drive(1'b1, v[i], rdy, 1'b0);
      if (i > 0) repeat ($urandom_range(0, max_gap)) drive(1'b0, 1'b0, rdy, 1'b0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n    = 1'b0;
    bit_valid  = 1'b0;
    health_clr = 1'b0;
    model_reset();
    #1;
    check("rst_word_valid", word_if.word_valid, 0);
    check("rst_word_data", word_if.word_data, 0);
    check("rst_health_fail", health_fail, 0);
    check("rst_overrun_cnt", overrun_cnt, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    model_step(1'b0, 1'b0, word_if.word_ready, 1'b0);
    #1;
  endtask

  // Monitor: per-cycle state comparison and handshake-driven scoreboard pops.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (reset_n === 1'b1) begin
        check("word_valid", word_if.word_valid, m_valid);
        check("health_fail", health_fail, m_fail);
        check("overrun_cnt", overrun_cnt, m_ovr);
        if (m_valid) check("word_data_hold", word_if.word_data, m_data);
        if (word_if.word_valid === 1'b1 && word_if.word_ready === 1'b1) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL word_pop: got 0x%0h, expected no word", word_if.word_data);
          end else begin
            check("word_pop", word_if.word_data, exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n            = 1'b0;
    bit_valid          = 1'b0;
    bit_in             = 1'b0;
    health_clr         = 1'b0;
    word_if.word_ready = 1'b0;
    model_reset();
    #2;
    check("init_word_valid", word_if.word_valid, 0);
    check("init_word_data", word_if.word_data, 0);
    check("init_health_fail", health_fail, 0);
    check("init_overrun_cnt", overrun_cnt, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Basic pack with a ready consumer.
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    send_bits(32'hB2, W, 1'b1, 0);
    check("basic_valid", word_if.word_valid, 1);
    check("basic_data", word_if.word_data, 8'hB2);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    check("basic_valid_drop", word_if.word_valid, 0);

    // Sparse input.
    send_bits(32'hB2, W, 1'b1, 3);
    check("sparse_valid", word_if.word_valid, 1);
    check("sparse_data", word_if.word_data, 8'hB2);
    drive(1'b0, 1'b0, 1'b1, 1'b0);

    // Backpressure: one word in the slot, one pending, three dropped.
    send_bits(32'hB2, W, 1'b0, 0);
    send_bits(32'h4D, W, 1'b0, 0);
    send_bits(32'h2, 3, 1'b0, 0);
    check("bp_data", word_if.word_data, 8'hB2);
    check("bp_overrun", overrun_cnt, 3);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    check("bp_xfer_valid", word_if.word_valid, 1);
    check("bp_xfer_data", word_if.word_data, 8'h4D);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    check("bp_drain_valid", word_if.word_valid, 0);

    // Overrun saturation: 16 bits fill slot and pending word, 20 more are dropped.
    for (int i = 0; i < 36; i++) drive(1'b1, (i % 2 == 0), 1'b0, 1'b0);
    check("sat_overrun", overrun_cnt, OVR_MAX);
    check("sat_data", word_if.word_data, 8'hAA);
    repeat (3) drive(1'b0, 1'b0, 1'b1, 1'b0);

    // Health failure on the fourth identical bit, then clear.
    send_bits(32'h0F, 5, 1'b1, 0);
    check("hf_flag", health_fail, 1);
    check("hf_no_word", word_if.word_valid, 0);
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    check("hf_clr", health_fail, 0);
    send_bits(32'hAA, W, 1'b1, 0);
    check("hf_after_valid", word_if.word_valid, 1);
    check("hf_after_data", word_if.word_data, 8'hAA);
    drive(1'b0, 1'b0, 1'b1, 1'b0);

    // Reset mid-word.
    send_bits(32'h19, 5, 1'b1, 0);
    do_reset();
    send_bits(32'h5A, W, 1'b1, 0);
    check("rst_mid_valid", word_if.word_valid, 1);
    check("rst_mid_data", word_if.word_data, 8'h5A);
    drive(1'b0, 1'b0, 1'b1, 1'b0);

    // Random traffic against the model.
    for (int i = 0; i < 2000; i++)
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));

    drive(1'b0, 1'b0, 1'b1, 1'b1);
    repeat (3) drive(1'b0, 1'b0, 1'b1, 1'b0);
    check("drain_words_left", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
